usb_encoder: RTL and testbench

USB_ENCODER -- requirements
Module: usb_encoder

---
 rtl/usb_encoder.sv | 252 +++++++++++++++++++++++++
 tb/tb_usb_encoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_encoder.sv
`timescale 1ns/1ps
// USB low/full-speed packet transmitter: SYNC, PID, optional DATA + CRC16, EOP.
// Applies bit stuffing and NRZI; each line bit lasts 4 clk cycles.
module usb_encoder (
  input  logic       clk,
  input  logic       rst0_async,
  input  logic       rst0_sync,
  input  logic       speed,
  input  logic       tx_req,
  input  logic [3:0] tx_pid,
  input  logic       tfifo_empty,
  input  logic [7:0] tfifo_data,
  output logic       tfifo_rd,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       dtx_plus,
  output logic       dtx_minus,
  output logic       dtx_oe,
  output logic [2:0] dbg_state
);

  // tx_req is a one-cycle strobe honoured only in IDLE; tfifo_rd pops the
  // show-ahead head byte that was sampled on the same edge it was raised.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SYNC    = 3'd1,
    S_PID     = 3'd2,
    S_DATA    = 3'd3,
    S_CRC     = 3'd4,
    S_EOP_SE0 = 3'd5,
    S_EOP_J   = 3'd6
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  phase, phase_nxt;
  logic [3:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  sr, sr_nxt;
  logic [15:0] crc, crc_nxt;
  logic [2:0]  ones, ones_nxt;
  logic        line_j, line_j_nxt;
  logic        spd, spd_nxt;
  logic        data_pkt, data_pkt_nxt;
  logic        rd_nxt, busy_nxt, done_nxt, oe_nxt, plus_nxt, minus_nxt;
  logic        send, raw, crc_upd, byte_bnd, lvl_base, in_bits;

  assign dbg_state = state;
  assign in_bits   = (state == S_SYNC) || (state == S_PID) ||
                     (state == S_DATA) || (state == S_CRC);
  assign lvl_base  = (state == S_IDLE) ? 1'b1 : line_j;

  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    bit_cnt_nxt  = bit_cnt;
    sr_nxt       = sr;
    crc_nxt      = crc;
    ones_nxt     = ones;
    line_j_nxt   = line_j;
    spd_nxt      = spd;
    data_pkt_nxt = data_pkt;
    rd_nxt       = 1'b0;
    busy_nxt     = tx_busy;
    done_nxt     = 1'b0;
    oe_nxt       = dtx_oe;
    plus_nxt     = dtx_plus;
    minus_nxt    = dtx_minus;
    send         = 1'b0;
    raw          = 1'b0;
    crc_upd      = 1'b0;
    byte_bnd     = 1'b0;

    if (state == S_IDLE) begin
      plus_nxt  = speed;
      minus_nxt = ~speed;
      if (tx_req) begin
        state_nxt    = S_SYNC;
        phase_nxt    = 2'd0;
        bit_cnt_nxt  = 4'd0;
        sr_nxt       = {~tx_pid, tx_pid};
        crc_nxt      = 16'hFFFF;
        spd_nxt      = speed;
        data_pkt_nxt = (tx_pid[2:0] == 3'b011);
        busy_nxt     = 1'b1;
        oe_nxt       = 1'b1;
        send         = 1'b1;
        raw          = 1'b0;
      end
    end else begin
      phase_nxt = phase + 2'd1;
      if (phase == 2'd3) begin
        if (in_bits && (ones == 3'd6)) begin
          // Stuffed zero: counters, shift register and CRC stay frozen.
          send = 1'b1;
          raw  = 1'b0;
        end else begin
          case (state)
            S_SYNC: begin
              send = 1'b1;
              if (bit_cnt != 4'd7) begin
                bit_cnt_nxt = bit_cnt + 4'd1;
                raw         = (bit_cnt == 4'd6);
              end else begin
                state_nxt   = S_PID;
                bit_cnt_nxt = 4'd0;
                raw         = sr[0];
              end
            end
            S_PID: begin
              if (bit_cnt != 4'd7) begin
                bit_cnt_nxt = bit_cnt + 4'd1;
                sr_nxt      = {1'b0, sr[7:1]};
                send        = 1'b1;
                raw         = sr[1];
              end else if (data_pkt) begin
                byte_bnd = 1'b1;
              end else begin
                state_nxt   = S_EOP_SE0;
                bit_cnt_nxt = 4'd0;
                plus_nxt    = 1'b0;
                minus_nxt   = 1'b0;
              end
            end
            S_DATA: begin
              if (bit_cnt != 4'd7) begin
                bit_cnt_nxt = bit_cnt + 4'd1;
                sr_nxt      = {1'b0, sr[7:1]};
                send        = 1'b1;
                raw         = sr[1];
                crc_upd     = 1'b1;
              end else begin
                byte_bnd = 1'b1;
              end
            end
            S_CRC: begin
              if (bit_cnt != 4'd15) begin
                bit_cnt_nxt = bit_cnt + 4'd1;
                crc_nxt     = {crc[14:0], 1'b0};
                send        = 1'b1;
                raw         = ~crc[14];
              end else begin
                state_nxt   = S_EOP_SE0;
                bit_cnt_nxt = 4'd0;
                plus_nxt    = 1'b0;
                minus_nxt   = 1'b0;
              end
            end
            S_EOP_SE0: begin
              if (bit_cnt == 4'd0) begin
                bit_cnt_nxt = 4'd1;
              end else begin
                state_nxt = S_EOP_J;
                plus_nxt  = spd;
                minus_nxt = ~spd;
              end
            end
            S_EOP_J: begin
              state_nxt = S_IDLE;
              busy_nxt  = 1'b0;
              oe_nxt    = 1'b0;
              done_nxt  = 1'b1;
              plus_nxt  = speed;
              minus_nxt = ~speed;
            end
            default: state_nxt = S_IDLE;
          endcase

          if (byte_bnd) begin
            bit_cnt_nxt = 4'd0;
            send        = 1'b1;
            if (!tfifo_empty) begin
              state_nxt = S_DATA;
              sr_nxt    = tfifo_data;
              rd_nxt    = 1'b1;
              raw       = tfifo_data[0];
              crc_upd   = 1'b1;
            end else begin
              state_nxt = S_CRC;
              raw       = ~crc[15];
            end
          end
        end
      end
    end

    if (crc_upd) begin
      crc_nxt = {crc[14:0], 1'b0} ^ ((crc[15] ^ raw) ? 16'h8005 : 16'h0000);
    end

    if (send) begin
      ones_nxt   = raw ? (ones + 3'd1) : 3'd0;
      line_j_nxt = raw ? lvl_base : ~lvl_base;
      plus_nxt   = line_j_nxt ? spd_nxt : ~spd_nxt;
      minus_nxt  = ~plus_nxt;
    end

    // Synchronous reset has exactly the effect of the asynchronous one.
    if (!rst0_sync) begin
      state_nxt    = S_IDLE;
      phase_nxt    = 2'd0;
      bit_cnt_nxt  = 4'd0;
      sr_nxt       = 8'd0;
      crc_nxt      = 16'd0;
      ones_nxt     = 3'd0;
      line_j_nxt   = 1'b0;
      spd_nxt      = 1'b0;
      data_pkt_nxt = 1'b0;
      rd_nxt       = 1'b0;
      busy_nxt     = 1'b0;
      done_nxt     = 1'b0;
      oe_nxt       = 1'b0;
      plus_nxt     = 1'b0;
      minus_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst0_async) begin
    if (!rst0_async) begin
      state     <= S_IDLE;
      phase     <= 2'd0;
      bit_cnt   <= 4'd0;
      sr        <= 8'd0;
      crc       <= 16'd0;
      ones      <= 3'd0;
      line_j    <= 1'b0;
      spd       <= 1'b0;
      data_pkt  <= 1'b0;
      tfifo_rd  <= 1'b0;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      dtx_oe    <= 1'b0;
      dtx_plus  <= 1'b0;
      dtx_minus <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      bit_cnt   <= bit_cnt_nxt;
      sr        <= sr_nxt;
      crc       <= crc_nxt;
      ones      <= ones_nxt;
      line_j    <= line_j_nxt;
      spd       <= spd_nxt;
      data_pkt  <= data_pkt_nxt;
      tfifo_rd  <= rd_nxt;
      tx_busy   <= busy_nxt;
      tx_done   <= done_nxt;
      dtx_oe    <= oe_nxt;
      dtx_plus  <= plus_nxt;
      dtx_minus <= minus_nxt;
    end
  end

endmodule

// File: tb/tb_usb_encoder.sv
`timescale 1ns/1ps
// Directed bench for usb_encoder: captures each packet per cycle, then
// NRZI-decodes and destuffs the line to compare against hand-derived streams.
module tb_usb_encoder;

  logic       clk = 1'b0;
  logic       rst0_async, rst0_sync, speed, tx_req;
  logic [3:0] tx_pid;
  logic       tfifo_empty;
  logic [7:0] tfifo_data;
  logic       tfifo_rd, tx_busy, tx_done, dtx_plus, dtx_minus, dtx_oe;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  usb_encoder dut (
    .clk(clk), .rst0_async(rst0_async), .rst0_sync(rst0_sync), .speed(speed),
    .tx_req(tx_req), .tx_pid(tx_pid), .tfifo_empty(tfifo_empty),
    .tfifo_data(tfifo_data), .tfifo_rd(tfifo_rd), .tx_busy(tx_busy),
    .tx_done(tx_done), .dtx_plus(dtx_plus), .dtx_minus(dtx_minus),
    .dtx_oe(dtx_oe), .dbg_state(dbg_state)
  );

  // Show-ahead FIFO model: bench owns wr_cnt, the pop process owns rd_ptr.
  logic [7:0] fifo_mem [0:255];
  int rd_ptr = 0;
  int wr_cnt = 0;
  assign tfifo_empty = (rd_ptr == wr_cnt);
  assign tfifo_data  = fifo_mem[rd_ptr[7:0]];
  always @(posedge clk) if (tfifo_rd && (rd_ptr != wr_cnt)) rd_ptr <= rd_ptr + 1;

  localparam int CAP = 4096;
  logic cap_p [CAP];
  logic cap_m [CAP];
  int   cap_len, oe_len, done_idx, rd_cnt;
  logic [0:2047] rx_raw, rx_ds;
  int   nraw, nds, shape_bad, stuff_bad, eop_bad;
  logic [7:0] pkt [0:63];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_pkt(input logic [3:0] pid);
    @(posedge clk); #1;
    tx_pid = pid;
    tx_req = 1'b1;
    @(posedge clk); #1;
    tx_req = 1'b0;
  endtask

  // Index 0 is the first cycle after the accepting edge; stops at tx_done.
  task automatic capture(input bit extra_req);
    cap_len = 0; oe_len = 0; done_idx = -1; rd_cnt = 0;
    for (int i = 0; i < CAP; i++) begin
      @(negedge clk);
      cap_p[i] = dtx_plus;
      cap_m[i] = dtx_minus;
      rd_cnt  += int'(tfifo_rd);
      if (dtx_oe && (oe_len == i)) oe_len++;
      cap_len = i + 1;
      if (extra_req) tx_req = (i == 10) || (i == 41) || (i == 75);
      if (tx_done) begin
        done_idx = i;
        break;
      end
    end
    tx_req = 1'b0;
  endtask

  task automatic decode(input logic spd);
    int   nb, ones, b0;
    logic prev, lvl, bit_v;
    rx_raw = '0; rx_ds = '0; nraw = 0; nds = 0;
    shape_bad = 0; stuff_bad = 0; eop_bad = 0;
    nb = oe_len / 4 - 3;
    if (nb < 0) nb = 0;
    prev = 1'b1;
    ones = 0;
    for (int k = 0; k < nb; k++) begin
      b0 = 4 * k;
      for (int j = 1; j < 4; j++)
        if ((cap_p[b0+j] !== cap_p[b0]) || (cap_m[b0+j] !== cap_m[b0])) shape_bad++;
      if (cap_p[b0] === cap_m[b0]) shape_bad++;
      lvl   = (cap_p[b0] === spd) && (cap_m[b0] === ~spd);
      bit_v = (lvl == prev);
      prev  = lvl;
      rx_raw[nraw] = bit_v;
      nraw++;
      if (ones == 6) begin
        if (bit_v) stuff_bad++;
        ones = 0;
      end else begin
        rx_ds[nds] = bit_v;
        nds++;
        ones = bit_v ? ones + 1 : 0;
      end
    end
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        if ((cap_p[4*nb+c] !== 1'b0) || (cap_m[4*nb+c] !== 1'b0)) eop_bad++;
      end else begin
        if ((cap_p[4*nb+c] !== spd) || (cap_m[4*nb+c] !== ~spd)) eop_bad++;
      end
    end
  endtask

  function automatic logic [7:0] ds_byte(input int idx);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) b[i] = rx_ds[8 + 8*idx + i];
    return b;
  endfunction

  // Reflected byte-wise form of CRC-16/USB; low byte goes on the wire first.
  function automatic logic [15:0] crc16_usb(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {8'h00, pkt[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic push_bytes(input int n);
    for (int j = 0; j < n; j++) fifo_mem[(wr_cnt + j) % 256] = pkt[j];
    wr_cnt = wr_cnt + n;
  endtask

  task automatic loopback(input int n);
    logic [15:0] crc_exp;
    int bad;
    for (int j = 0; j < n; j++) pkt[j] = 8'(j * 37 + 5);
    push_bytes(n);
    start_pkt(4'b0011);
    capture(1'b0);
    decode(1'b1);
    crc_exp = crc16_usb(n);
    bad = 0;
    for (int j = 0; j < n; j++) if (ds_byte(1 + j) !== pkt[j]) bad++;
    check_eq($sformatf("lb%0d_rd", n), 64'(rd_cnt), 64'(n));
    check_eq($sformatf("lb%0d_len", n), 64'(nds), 64'(32 + 8*n));
    check_eq($sformatf("lb%0d_pid", n), 64'(ds_byte(0)), 64'(8'hC3));
    check_eq($sformatf("lb%0d_data", n), 64'(bad), 64'(0));
    check_eq($sformatf("lb%0d_crc", n), 64'({ds_byte(2 + n), ds_byte(1 + n)}), 64'(crc_exp));
    check_eq($sformatf("lb%0d_line", n), 64'(shape_bad + stuff_bad + eop_bad), 64'(0));
  endtask

  initial begin
    rst0_async = 1'b0; rst0_sync = 1'b1; speed = 1'b1; tx_req = 1'b0; tx_pid = 4'h0;
    repeat (2) @(negedge clk);
    check_eq("reset_outs", 64'({dtx_oe, dtx_plus, dtx_minus, tfifo_rd, tx_busy, tx_done}), 64'(0));
    check_eq("reset_state", 64'(dbg_state), 64'(0));
    rst0_async = 1'b1;
    @(negedge clk);
    check_eq("idle_j_fs", 64'({dtx_plus, dtx_minus}), 64'(2'b10));

    // ACK, full speed
    start_pkt(4'b0010);
    capture(1'b0);
    decode(1'b1);
    check_eq("ack_oe_len", 64'(oe_len), 64'(76));
    check_eq("ack_done_idx", 64'(done_idx), 64'(76));
    check_eq("ack_nbits", 64'(nraw), 64'(16));
    check_eq("ack_bits", 64'(rx_raw[0:63]), {16'b00000001_01001011, 48'd0});
    check_eq("ack_line", 64'(shape_bad + eop_bad), 64'(0));
    @(negedge clk);
    check_eq("ack_done_1cyc", 64'({tx_done, dtx_oe, tx_busy}), 64'(0));

    // Requests while busy must not disturb the packet
    start_pkt(4'b0010);
    capture(1'b1);
    decode(1'b1);
    check_eq("busy_req_oe_len", 64'(oe_len), 64'(76));
    check_eq("busy_req_done", 64'(done_idx), 64'(76));
    check_eq("busy_req_bits", 64'(rx_raw[0:63]), {16'b00000001_01001011, 48'd0});

    // Request in the tx_done cycle starts the next packet at once
    start_pkt(4'b0010);
    capture(1'b0);
    tx_req = 1'b1;
    @(posedge clk); #1;
    tx_req = 1'b0;
    @(negedge clk);
    check_eq("b2b_start", 64'({dtx_oe, tx_busy}), 64'(2'b11));
    capture(1'b0);
    check_eq("b2b_done", 64'(done_idx), 64'(75));

    // DATA0 zero-length: CRC of no data is 0x0000 on the wire
    start_pkt(4'b0011);
    capture(1'b0);
    decode(1'b1);
    check_eq("z_oe_len", 64'(oe_len), 64'(140));
    check_eq("z_rd", 64'(rd_cnt), 64'(0));
    check_eq("z_bits", 64'(rx_raw[0:63]), {32'b00000001_11000011_00000000_00000000, 32'd0});

    // DATA1 0xFF: stuff after the 6th one; CRC 0xFF00 ends in eight 1s, adding a second stuff
    pkt[0] = 8'hFF;
    push_bytes(1);
    start_pkt(4'b1011);
    capture(1'b0);
    decode(1'b1);
    check_eq("ff_rd", 64'(rd_cnt), 64'(1));
    check_eq("ff_nbits", 64'(nraw), 64'(42));
    check_eq("ff_bits", 64'(rx_raw[0:63]),
             {42'b00000001_11010010_111111011_00000000_111111011, 22'd0});
    check_eq("ff_oe_len", 64'(oe_len), 64'(180));
    check_eq("ff_stuff", 64'(stuff_bad + shape_bad + eop_bad), 64'(0));

    loopback(0);
    loopback(1);
    loopback(8);
    loopback(64);

    // Low speed; speed flips during the packet and must be ignored
    speed = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_j_ls", 64'({dtx_plus, dtx_minus}), 64'(2'b01));
    start_pkt(4'b0010);
    speed = 1'b1;
    capture(1'b0);
    decode(1'b0);
    check_eq("ls_first_k", 64'({cap_p[0], cap_m[0]}), 64'(2'b10));
    check_eq("ls_bits", 64'(rx_raw[0:63]), {16'b00000001_01001011, 48'd0});
    check_eq("ls_line", 64'(shape_bad + eop_bad + oe_len), 64'(76));
    @(negedge clk);
    check_eq("ls_idle_back_fs", 64'({dtx_plus, dtx_minus}), 64'(2'b10));

    // Synchronous reset in the middle of DATA
    pkt[0] = 8'h5A; pkt[1] = 8'hA5;
    push_bytes(2);
    start_pkt(4'b0011);
    rd_cnt = 0;
    for (int i = 0; i < 71; i++) begin
      @(negedge clk);
      rd_cnt += int'(tfifo_rd);
    end
    rst0_sync = 1'b0;
    @(posedge clk); #1;
    rst0_sync = 1'b1;
    @(negedge clk);
    check_eq("srst_outs", 64'({dtx_oe, tx_busy, tx_done, tfifo_rd, dtx_plus, dtx_minus}), 64'(0));
    check_eq("srst_rd_before", 64'(rd_cnt), 64'(1));
    @(negedge clk);
    check_eq("srst_idle_j", 64'({dtx_plus, dtx_minus, dtx_oe}), 64'(3'b100));
    begin
      int dn, rn;
      dn = 0; rn = 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        dn += int'(tx_done);
        rn += int'(tfifo_rd);
      end
      check_eq("srst_no_done", 64'(dn), 64'(0));
      check_eq("srst_no_pop", 64'(rn), 64'(0));
    end
    wr_cnt = rd_ptr;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
